// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA H/V timing, sync generation and selectable test patterns.
// All outputs are registered from the same (h,v), giving one cycle of latency.
module vga_pattern_gen #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 40,
   parameter int   H_SYNC   = 128,
   parameter int   H_BP     = 88,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 4,
   parameter int   V_BP     = 23,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   CW       = 4,
   parameter int   CNT_W    = 11
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [1:0]       mode,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic [CW-1:0]    r,
   output logic [CW-1:0]    g,
   output logic [CW-1:0]    b,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             frame_start,
   output logic [7:0]       frame_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BW      = H_ACTIVE / 8;
   localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS0    = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS1    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS0    = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS1    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] BW_END = CNT_W'(BW - 1);
   localparam logic [CW-1:0]    F      = '1;
   localparam logic [CW-1:0]    Z      = '0;
   localparam logic [2*CW-1:0]  GRAY_W = {CW{2'b10}};
   localparam logic [CW-1:0]    GRAY   = GRAY_W[2*CW-1 -: CW];
   // {r,g,b} codes, bar 0 in the low bits: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [23:0]      BARS   = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};

   logic [CNT_W-1:0] r_h, r_v, r_bpos, w_x;
   logic [3:0]       r_bar;
   logic [1:0]       r_mode, w_mode;
   logic             r_first, w_bound, w_de, w_chk;
   logic [2:0]       w_bar;
   logic [7:0]       w_fcnt;
   logic [3*CW-1:0]  w_border, w_rgb;

   // The boundary pixel already uses the newly sampled mode and frame count
   always_comb begin
      w_bound  = r_h == '0 && r_v == '0;
      w_mode   = w_bound ? mode : r_mode;
      w_fcnt   = w_bound && !r_first ? frame_cnt + 8'd1 : frame_cnt;
      w_de     = r_h < HA && r_v < VA;
      w_x      = r_h + (w_mode == 2'd3 ? CNT_W'(w_fcnt) : '0);
      w_chk    = w_x[5] ^ r_v[5];
      w_bar    = r_bar[3] ? 3'b000 : BARS[3*r_bar[2:0] +: 3];
      w_border = r_v == '0 ? {F, F, Z} : r_v == V_LAST ? {F, Z, Z} :
                 r_h == '0 ? {Z, F, Z} : r_h == H_LAST ? {Z, Z, F} : {GRAY, GRAY, GRAY};
      w_rgb    = w_mode == 2'd0 ? w_border :
                 w_mode == 2'd1 ? {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}} : {3*CW{w_chk}};
   end

   always_ff @(posedge pclk or posedge rst)
      if (rst) begin
         r_h         <= '0;
         r_v         <= '0;
         r_bpos      <= '0;
         r_bar       <= '0;
         r_mode      <= '0;
         r_first     <= 1'b1;
         hs          <= !HS_POL;
         vs          <= !VS_POL;
         de          <= 1'b0;
         {r, g, b}   <= '0;
         hcount      <= '0;
         vcount      <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         r_h         <= r_h == H_END ? '0 : r_h + 1'b1;
         if (r_h == H_END) r_v <= r_v == V_END ? '0 : r_v + 1'b1;
         // bar index tracks h/BW incrementally; it saturates at 8 (black tail)
         r_bpos      <= r_h == H_END || r_bpos == BW_END ? '0 : r_bpos + 1'b1;
         if (r_h == H_END) r_bar <= '0;
         else if (r_bpos == BW_END && !r_bar[3]) r_bar <= r_bar + 4'd1;
         r_mode      <= w_mode;
         r_first     <= r_first && !w_bound;
         hs          <= r_h >= HS0 && r_h < HS1 ? HS_POL : !HS_POL;
         vs          <= r_v >= VS0 && r_v < VS1 ? VS_POL : !VS_POL;
         de          <= w_de;
         {r, g, b}   <= w_de ? w_rgb : '0;
         hcount      <= r_h;
         vcount      <= r_v;
         frame_start <= w_bound;
         frame_cnt   <= w_fcnt;
      end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench; a small 117x47 instance for timing/patterns
// and a tiny 11x7 instance for the 257-frame frame_cnt wrap and scroll.
module tb_vga_pattern_gen;
   logic       clk = 1'b0, rst = 1'b1, rst_t = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       hs, vs, de, fs;
   logic [3:0] r, g, b;
   logic [7:0] hcount, vcount, fc;
   logic        t_hs, t_vs, t_de, t_fs;
   logic [3:0]  t_r, t_g, t_b;
   logic [10:0] t_hc, t_vc;
   logic [7:0]  t_fc;
   int checks = 0, errors = 0;

   typedef struct {int x; int y; int fc; int rgb; string nm;} exp_t;
   exp_t q[$];
   int   tq[$];

   vga_pattern_gen #(.H_ACTIVE(100), .H_FP(4), .H_SYNC(8), .H_BP(5),
                     .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(2),
                     .HS_POL(1'b1), .VS_POL(1'b0), .CW(4), .CNT_W(8)) dut (
      .pclk(clk), .rst(rst), .mode(mode), .hs(hs), .vs(vs), .de(de),
      .r(r), .g(g), .b(b), .hcount(hcount), .vcount(vcount),
      .frame_start(fs), .frame_cnt(fc));

   vga_pattern_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) tiny (
      .pclk(clk), .rst(rst_t), .mode(2'd3), .hs(t_hs), .vs(t_vs), .de(t_de),
      .r(t_r), .g(t_g), .b(t_b), .hcount(t_hc), .vcount(t_vc),
      .frame_start(t_fs), .frame_cnt(t_fc));

   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail(string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic push(int x, int y, int f, int rgb, string nm);
      exp_t e;
      e.x = x; e.y = y; e.fc = f; e.rgb = rgb; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic wait_pix(int x, int y);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(int'(hcount) == x && int'(vcount) == y) && n < 12000);
      if (n >= 12000) fail($sformatf("wait_pix_%0d_%0d", x, y));
   endtask

   task automatic wait_empty(int budget);
      int n = 0;
      while (q.size() > 0 && n < budget) begin @(negedge clk); n++; end
      while (q.size() > 0) begin fail(q[0].nm); void'(q.pop_front()); end
   endtask

   // pixel monitor: an entry is due when position and frame count line up
   always @(negedge clk)
      if (!rst && q.size() > 0 && int'(hcount) == q[0].x && int'(vcount) == q[0].y && int'(fc) == q[0].fc) begin
         chk(q[0].nm, int'({r, g, b}), q[0].rgb);
         void'(q.pop_front());
      end

   always @(negedge clk)
      if (!rst_t && t_fs && tq.size() > 0) begin
         int e;
         e = tq.pop_front();
         chk("tiny_fc", int'(t_fc), e);
         chk("tiny_pix00", int'({t_r, t_g, t_b}), e[5] ? 'hFFF : 0);
         chk("tiny_pos", int'(t_hc) + int'(t_vc), 0);
      end

   initial begin
      int n, hs_n, hs_first, de_n, vs_n, vs_first;
      for (int i = 0; i < 257; i++) tq.push_back(i % 256);
      repeat (3) @(negedge clk);
      chk("rst_hs", int'(hs), 0);
      chk("rst_vs", int'(vs), 1);
      chk("rst_de", int'(de), 0);
      chk("rst_rgb", int'({r, g, b}), 0);
      chk("rst_fs", int'(fs), 0);
      chk("rst_fc", int'(fc), 0);
      push(0, 0, 0, 'hFF0, "m0_top_left");   push(5, 0, 0, 'hFF0, "m0_top");
      push(0, 5, 0, 'h0F0, "m0_left");       push(99, 5, 0, 'h00F, "m0_right");
      push(50, 20, 0, 'hAAA, "m0_gray");     push(110, 20, 0, 'h000, "m0_blank");
      push(0, 39, 0, 'hF00, "m0_bot_left");  push(5, 39, 0, 'hF00, "m0_bottom");
      push(50, 20, 1, 'hAAA, "sync_m0_hold"); push(99, 30, 1, 'h00F, "sync_m0_right");
      push(0, 0, 2, 'hFFF, "m1_white0");     push(11, 0, 2, 'hFFF, "m1_white11");
      push(12, 0, 2, 'hFF0, "m1_yellow");    push(30, 3, 2, 'h0FF, "m1_cyan");
      push(40, 3, 2, 'h0F0, "m1_green");     push(50, 3, 2, 'hF0F, "m1_magenta");
      push(65, 3, 2, 'hF00, "m1_red");       push(80, 3, 2, 'h00F, "m1_blue");
      push(90, 3, 2, 'h000, "m1_black");     push(96, 3, 2, 'h000, "m1_tail96");
      push(99, 3, 2, 'h000, "m1_tail99");    push(105, 3, 2, 'h000, "m1_blank");
      push(60, 30, 2, 'hF00, "sync_m1_hold");
      push(0, 0, 3, 'h000, "m2_00");         push(32, 0, 3, 'hFFF, "m2_32_0");
      push(96, 0, 3, 'hFFF, "m2_96_0");      push(31, 31, 3, 'h000, "m2_31_31");
      push(0, 32, 3, 'hFFF, "m2_0_32");      push(32, 32, 3, 'h000, "m2_32_32");
      push(29, 35, 3, 'hFFF, "sync_m2_hold");
      push(27, 0, 4, 'h000, "m3_27_0");      push(28, 0, 4, 'hFFF, "m3_28_0");
      push(27, 32, 4, 'hFFF, "m3_27_32");    push(28, 32, 4, 'h000, "m3_28_32");
      #1 rst = 1'b0; rst_t = 1'b0;
      @(negedge clk);
      chk("first_fs", int'(fs), 1);
      chk("first_hc", int'(hcount), 0);
      chk("first_vc", int'(vcount), 0);
      chk("first_fc", int'(fc), 0);
      @(negedge clk);
      chk("second_fs", int'(fs), 0);
      chk("second_hc", int'(hcount), 1);
      wait_pix(0, 1);
      hs_n = 0; hs_first = -1; de_n = 0;
      for (int i = 0; i < 117; i++) begin
         if (hs) begin hs_n++; if (hs_first < 0) hs_first = int'(hcount); end
         if (de) de_n++;
         @(negedge clk);
      end
      chk("hs_width", hs_n, 8);
      chk("hs_start", hs_first, 104);
      chk("de_per_line", de_n, 100);
      n = 0; vs_n = 0; vs_first = -1;
      while (!fs && n < 12000) begin
         if (hcount == 8'd0 && !vs) begin vs_n++; if (vs_first < 0) vs_first = int'(vcount); end
         @(negedge clk);
         n++;
      end
      chk("frame1_start", int'(fs), 1);
      chk("vs_lines", vs_n, 3);
      chk("vs_first", vs_first, 42);
      mode = 2'd1;
      n = 0;
      do begin @(negedge clk); n++; end while (!fs && n < 12000);
      chk("frame_period", n, 5499);
      wait_pix(50, 20);
      mode = 2'd2;
      wait_pix(50, 20);
      mode = 2'd3;
      wait_empty(12000);
      wait_pix(106, 43);
      chk("pre_rst_hs", int'(hs), 1);
      chk("pre_rst_vs", int'(vs), 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_hs", int'(hs), 0);
      chk("mid_rst_vs", int'(vs), 1);
      chk("mid_rst_de", int'(de), 0);
      chk("mid_rst_rgb", int'({r, g, b}), 0);
      chk("mid_rst_hc", int'(hcount), 0);
      chk("mid_rst_vc", int'(vcount), 0);
      chk("mid_rst_fc", int'(fc), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      push(0, 0, 0, 'h000, "post_m3_00");
      push(32, 0, 0, 'hFFF, "post_m3_32_0");
      push(5, 39, 0, 'hFFF, "post_m3_5_39");
      @(negedge clk);
      chk("post_fs", int'(fs), 1);
      chk("post_hc", int'(hcount), 0);
      chk("post_vc", int'(vcount), 0);
      chk("post_fc", int'(fc), 0);
      wait_empty(12000);
      n = 0;
      while (tq.size() > 0 && n < 30000) begin @(negedge clk); n++; end
      if (tq.size() > 0) fail("tiny_frames");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
